// File: rtl/otn_send_tran.sv
// otn_send_tran: buffers one frame of payload bytes from the mapper, sends it
// LSB-first behind a six-byte frame-alignment pattern on a single serial line,
// and in ARQ mode waits for a 3-bit ack, replaying the buffer on a bad or
// missing ack until the retry budget runs out.
module otn_send_tran #(
  parameter int FRAME_BYTES = 4158,
  parameter int BAUD_DIV    = 20,
  parameter int ACK_TIMEOUT = 65535,
  parameter int MAX_RETRY   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk_en_16_x_baud,
  input  logic [7:0] i_frame_data,
  input  logic       i_frame_valid,
  output logic       o_frame_ready,
  input  logic       i_arq_en,
  output logic       o_otn_tx_data,
  input  logic       i_otn_rx_ack,
  output logic       o_frame_done,
  output logic       o_frame_fail,
  output logic       o_busy
);

  localparam int AW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [12:0]   LAST_ADDR = 13'(FRAME_BYTES - 1);
  localparam logic [12:0]   FAS_LAST  = 13'd5;
  localparam logic [4:0]    DIV_LAST  = 5'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND_FAS, S_SEND_DATA, S_WAIT_ACK, S_RETRY
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [FRAME_BYTES];
  logic [12:0]   r_addr;
  logic [4:0]    r_div;
  logic [2:0]    r_bit;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retry;
  logic          r_arq, r_ack_s1, r_ack_s2, r_ack_start;
  logic          r_ready, r_done, r_fail;
  logic          w_done_nxt, w_fail_nxt;
  logic          w_accept, w_sending, w_bit_end, w_byte_end, w_tx;
  logic [7:0]    w_mem_byte, w_cur_byte;
  logic [AW-1:0] w_wr_addr;

  // Alignment pattern: three F6 bytes followed by three 28 bytes.
  function automatic logic [7:0] fas_byte(input logic [12:0] idx);
    logic [7:0] b;
    if (idx < 13'd3) b = 8'hF6;
    else             b = 8'h28;
    return b;
  endfunction

  assign w_accept   = i_frame_valid & r_ready;
  assign w_sending  = (r_state == S_SEND_FAS) || (r_state == S_SEND_DATA);
  assign w_bit_end  = w_sending && i_sclk_en_16_x_baud && (r_div == DIV_LAST);
  assign w_byte_end = w_bit_end && (r_bit == 3'd7);
  assign w_mem_byte = r_mem[r_addr[AW-1:0]];
  assign w_wr_addr  = (r_state == S_IDLE) ? AW'(0) : r_addr[AW-1:0];

  // Line driver: current bit of the pattern or buffered byte, idle high otherwise.
  always_comb begin
    w_cur_byte = w_mem_byte;
    w_tx       = 1'b1;
    if (r_state == S_SEND_FAS) w_cur_byte = fas_byte(r_addr);
    else                       w_cur_byte = w_mem_byte;
    if (w_sending) w_tx = w_cur_byte[r_bit];
    else           w_tx = 1'b1;
  end

  // Next-state and completion pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_fail_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LAST_ADDR == 13'd0) w_state_nxt = S_SEND_FAS;
          else                    w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_accept && (r_addr == LAST_ADDR)) w_state_nxt = S_SEND_FAS;
        else                                   w_state_nxt = S_LOAD;
      end
      S_SEND_FAS: begin
        if (w_byte_end && (r_addr == FAS_LAST)) w_state_nxt = S_SEND_DATA;
        else                                    w_state_nxt = S_SEND_FAS;
      end
      S_SEND_DATA: begin
        if (w_byte_end && (r_addr == LAST_ADDR)) begin
          if (r_arq) begin
            w_state_nxt = S_WAIT_ACK;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = S_SEND_DATA;
        end
      end
      S_WAIT_ACK: begin
        if (r_ack_start) begin
          // The cycle after the start bit carries the verdict.
          if (r_ack_s2) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RETRY;
          end
        end else if (!r_ack_s2) begin
          w_state_nxt = S_WAIT_ACK;
        end else if (r_timer == TMO_LAST) begin
          w_state_nxt = S_RETRY;
        end else begin
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_RETRY: begin
        if (r_retry < RETRY_MAX) begin
          w_state_nxt = S_SEND_FAS;
        end else begin
          w_state_nxt = S_IDLE;
          w_fail_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, counters and registered outputs; entering a state clears its counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= 13'd0;
      r_div       <= 5'd0;
      r_bit       <= 3'd0;
      r_timer     <= TW'(0);
      r_retry     <= RW'(0);
      r_arq       <= 1'b0;
      r_ack_start <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_fail  <= w_fail_nxt;
      r_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_arq  <= i_arq_en;
            r_addr <= 13'd1;
          end
        end
        S_LOAD: begin
          if (w_accept) r_addr <= r_addr + 13'd1;
        end
        S_SEND_FAS, S_SEND_DATA: begin
          if (i_sclk_en_16_x_baud) begin
            if (w_bit_end) begin
              r_div <= 5'd0;
              r_bit <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_addr <= r_addr + 13'd1;
            end else begin
              r_div <= r_div + 5'd1;
            end
          end
        end
        S_WAIT_ACK: begin
          r_timer <= r_timer + TW'(1);
          if (!r_ack_start && !r_ack_s2) r_ack_start <= 1'b1;
        end
        S_RETRY: begin
          if (r_retry < RETRY_MAX) r_retry <= r_retry + RW'(1);
          else                     r_retry <= RW'(0);
        end
        default: ;
      endcase
      if (w_done_nxt) r_retry <= RW'(0);
      if (w_state_nxt != r_state) begin
        case (w_state_nxt)
          S_SEND_FAS, S_SEND_DATA: begin
            r_addr <= 13'd0;
            r_div  <= 5'd0;
            r_bit  <= 3'd0;
          end
          S_WAIT_ACK: begin
            r_timer     <= TW'(0);
            r_ack_start <= 1'b0;
          end
          S_IDLE: r_addr <= 13'd0;
          default: ;
        endcase
      end
    end
  end

  // Two-flop synchronizer for the asynchronous ack line, idling high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack_s1 <= 1'b1;
      r_ack_s2 <= 1'b1;
    end else begin
      r_ack_s1 <= i_otn_rx_ack;
      r_ack_s2 <= r_ack_s1;
    end
  end

  // Frame buffer write port; contents survive retries so frames replay without reload.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_mem[w_wr_addr] <= i_frame_data;
  end

  assign o_frame_ready = r_ready;
  assign o_frame_done  = r_done;
  assign o_frame_fail  = r_fail;
  assign o_busy        = (r_state != S_IDLE);
  assign o_otn_tx_data = w_tx;

endmodule

// File: doc/otn_send_tran.md
OTN_SEND_TRAN -- requirements
Module: otn_send_tran

Interface
REQ-001 Parameter FRAME_BYTES, default 4158: payload bytes per frame, sent after the frame-alignment pattern.
REQ-002 Parameter BAUD_DIV, default 20: number of i_sclk_en_16_x_baud pulses per serial bit.
REQ-003 Parameter ACK_TIMEOUT, default 65535: i_clk cycles to wait for an ack before declaring it bad.
REQ-004 Parameter MAX_RETRY, default 3: maximum retransmissions per frame.
REQ-005 i_clk  in  1  clock; all logic is on the rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_sclk_en_16_x_baud  in  1  one-cycle baud-tick enable.
REQ-008 i_frame_data  in  8  payload byte from the mapper.
REQ-009 i_frame_valid  in  1  i_frame_data is valid.
REQ-010 o_frame_ready  out  1  block accepts a byte this cycle.
REQ-011 i_arq_en  in  1  ARQ mode, sampled at the first accepted byte of a frame.
REQ-012 o_otn_tx_data  out  1  serial line, idle high.
REQ-013 i_otn_rx_ack  in  1  ack line from the far receiver, idle high.
REQ-014 o_frame_done  out  1  one-cycle pulse: frame delivered (good ack, or ARQ off).
REQ-015 o_frame_fail  out  1  one-cycle pulse: frame dropped after the retries are exhausted.
REQ-016 o_busy  out  1  high in every state except IDLE.

Function
REQ-017 Frame buffer: FRAME_BYTES x 8 inferred RAM with a 13-bit address; it holds the current frame for replay.
REQ-018 States are IDLE, LOAD, SEND_FAS, SEND_DATA, WAIT_ACK and RETRY.
REQ-019 IDLE: o_frame_ready=1; the first valid&ready byte is written to address 0, i_arq_en is latched, and the state goes to LOAD.
REQ-020 LOAD: o_frame_ready=1; each valid&ready byte is written at the incrementing address.
REQ-021 LOAD exit: after byte FRAME_BYTES-1 is written, o_frame_ready drops in the next cycle and the state goes to SEND_FAS.
REQ-022 Flow control: no byte is accepted outside IDLE/LOAD, and gaps in i_frame_valid are tolerated.
REQ-023 Bit timer: a 5-bit divider counts i_sclk_en_16_x_baud pulses, and a bit ends on the pulse where the divider is BAUD_DIV-1.
REQ-024 The divider is cleared on entry to SEND_FAS.
REQ-025 Bit order: LSB first, with no start or stop bits; each bit is held for exactly BAUD_DIV ticks.
REQ-026 SEND_FAS transmits bytes F6,F6,F6,28,28,28 (48 bits), then goes to SEND_DATA with no idle gap.
REQ-027 SEND_DATA transmits buffer addresses 0..FRAME_BYTES-1 back to back.
REQ-028 SEND_DATA exit: after the last bit, go to WAIT_ACK if ARQ was latched, else pulse o_frame_done and return to IDLE.
REQ-029 o_otn_tx_data=1 in IDLE, LOAD, WAIT_ACK and RETRY.
REQ-030 i_otn_rx_ack passes through a 2-flop synchronizer with reset value 1.
REQ-031 Ack format, one bit per i_clk cycle: start 0, data bit (1=good, 0=bad), stop 0.
REQ-032 WAIT_ACK: the first synchronized 0 is the start bit, and the next cycle's value is the data bit.
REQ-033 Good ack: pulse o_frame_done, clear the retry count, and go to IDLE.
REQ-034 Bad ack: go to RETRY.
REQ-035 Ack timeout: a timer is cleared on WAIT_ACK entry, and reaching ACK_TIMEOUT with no start bit counts as a bad ack.
REQ-036 RETRY: if retry_cnt<MAX_RETRY, increment it and go to SEND_FAS, replaying from the buffer with no reload.
REQ-037 Retries exhausted: otherwise pulse o_frame_fail, clear retry_cnt, and go to IDLE.
REQ-038 Activity on the ack line outside WAIT_ACK is ignored.
REQ-039 Boundary: a baud tick that coincides with the SEND_FAS entry cycle does not advance the divider.
REQ-040 Boundary: the ack start-bit search begins only once the state is WAIT_ACK, never in the final SEND_DATA cycle.

Reset
REQ-041 i_rst overrides all events and takes effect at the next edge, including mid-frame and mid-ack.
REQ-042 Reset state: IDLE; o_otn_tx_data=1, o_frame_ready=0 during reset then 1, o_frame_done=0, o_frame_fail=0, o_busy=0.
REQ-043 Reset clears the counters, divider, retry_cnt and synchronizer; the buffer contents are don't-care.

Verification (FRAME_BYTES=4, BAUD_DIV=20, MAX_RETRY=2)
REQ-044 Load 11,22,33,44 with ARQ=0 and a tick every cycle -> line shows F6F6F6282828 11223344 LSB-first, 20 cycles/bit; o_frame_done one cycle after the last bit; 0 bytes accepted while busy.
REQ-045 ARQ=1, ack sequence 0,1,0 after the frame -> o_frame_done pulse, no retransmission.
REQ-046 ARQ=1, ack 0,0,0 twice then 0,1,0 -> line carries three identical frames, then o_frame_done; retry_cnt reaches 2.
REQ-047 ARQ=1, ack held high -> timeout, two retransmissions, then o_frame_fail after 3 x ACK_TIMEOUT waits; no o_frame_done.
REQ-048 i_frame_valid toggling 1,0,1,0 during LOAD -> buffer holds the correct 4 bytes in order, and the transmitted payload matches.
REQ-049 i_rst asserted in SEND_DATA bit 13 -> next cycle o_otn_tx_data=1, o_busy=0, state IDLE; a new frame then loads and sends correctly.
